// File: rtl/axi_sram_slave_if.sv
// AXI4-subset channel bundle between the self-test master and the SRAM slave.
// Signal names keep the slave's i_/o_ view so both ends share one definition.
interface axi_sram_slave_if #(
    parameter int unsigned AW = 25,
    parameter int unsigned DW = 16
);
    logic          i_awvalid;
    logic          o_awready;
    logic [AW-1:0] i_awaddr;
    logic [7:0]    i_awlen;
    logic          i_wvalid;
    logic          o_wready;
    logic          i_wlast;
    logic [DW-1:0] i_wdata;
    logic          o_bvalid;
    logic          i_bready;
    logic          i_arvalid;
    logic          o_arready;
    logic [AW-1:0] i_araddr;
    logic [7:0]    i_arlen;
    logic          o_rvalid;
    logic          i_rready;
    logic          o_rlast;
    logic [DW-1:0] o_rdata;
    logic          o_err;

    modport slave (
        input  i_awvalid, i_awaddr, i_awlen, i_wvalid, i_wlast, i_wdata,
               i_bready, i_arvalid, i_araddr, i_arlen, i_rready,
        output o_awready, o_wready, o_bvalid, o_arready, o_rvalid, o_rlast,
               o_rdata, o_err
    );

    modport master (
        output i_awvalid, i_awaddr, i_awlen, i_wvalid, i_wlast, i_wdata,
               i_bready, i_arvalid, i_araddr, i_arlen, i_rready,
        input  o_awready, o_wready, o_bvalid, o_arready, o_rvalid, o_rlast,
               o_rdata, o_err
    );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI4-subset slave backed by a single-port synchronous RAM; one burst at a
// time, write/read arbitrated round-robin. Stand-in for the DDR controller.
// Optional feature: define AXI_SRAM_SLAVE_RANDOM_STALL_EN to insert
// LFSR-driven wready drops and rvalid bubbles for master backpressure testing.
module axi_sram_slave #(
    parameter int unsigned AW      = 25,
    parameter int unsigned DW      = 16,
    parameter int unsigned D_LEVEL = 1,
    parameter int unsigned MEM_AW  = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    axi_sram_slave_if.slave bus
);
    localparam int unsigned DEPTH  = 1 << MEM_AW;
    localparam int unsigned IDX_LO = D_LEVEL;
    localparam int unsigned IDX_HI = MEM_AW + D_LEVEL - 1;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WRESP,
        READ_FETCH,
        READ
    } state_t;

    state_t            state;
    logic [MEM_AW-1:0] idx;
    logic [7:0]        cnt;
    logic              last_rd;
    logic [DW-1:0]     mem [DEPTH];
    logic [MEM_AW-1:0] ram_addr;
    logic              aw_hs;
    logic              ar_hs;
    logic              w_hs;
    logic              r_hs;
    logic              stall;
    logic              rd_load;
    logic              unused_addr;

    // Address-channel grant: single requester wins, conflicts alternate.
    assign bus.o_awready = (state == IDLE) & bus.i_awvalid & (~bus.i_arvalid | last_rd);
    assign bus.o_arready = (state == IDLE) & bus.i_arvalid & (~bus.i_awvalid | ~last_rd);

    assign aw_hs = bus.i_awvalid & bus.o_awready;
    assign ar_hs = bus.i_arvalid & bus.o_arready;
    assign w_hs  = bus.i_wvalid & bus.o_wready;
    assign r_hs  = bus.o_rvalid & bus.i_rready;

    // Prefetch the next beat on an R handshake so it is ready next cycle.
    assign ram_addr = r_hs ? idx + MEM_AW'(1) : idx;
    assign rd_load  = (state == READ_FETCH) | ((state == READ) & ~(r_hs & (cnt == 8'd0)));

    // Address bits outside the RAM word index are intentionally ignored.
    assign unused_addr = ^{bus.i_awaddr[AW-1:IDX_HI+1], bus.i_awaddr[IDX_LO-1:0],
                           bus.i_araddr[AW-1:IDX_HI+1], bus.i_araddr[IDX_LO-1:0]};

`ifdef AXI_SRAM_SLAVE_RANDOM_STALL_EN
    logic [15:0] lfsr;

    // Free-running LFSR (x^16+x^14+x^13+x^11+1) selecting stall cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign stall = (lfsr[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    // RAM write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_hs) begin
            mem[idx] <= bus.i_wdata;
        end
    end

    // Burst FSM with registered channel outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            last_rd     <= 1'b1;
            bus.o_wready <= 1'b0;
            bus.o_bvalid <= 1'b0;
            bus.o_rvalid <= 1'b0;
            bus.o_rlast  <= 1'b0;
            bus.o_rdata  <= '0;
            bus.o_err    <= 1'b0;
        end else begin
            if (w_hs && (bus.i_wlast != (cnt == 8'd0))) begin
                bus.o_err <= 1'b1;
            end
            if (rd_load) begin
                bus.o_rdata <= mem[ram_addr];
            end
            case (state)
                IDLE: begin
                    if (aw_hs) begin
                        idx          <= bus.i_awaddr[IDX_HI:IDX_LO];
                        cnt          <= bus.i_awlen;
                        last_rd      <= 1'b0;
                        bus.o_wready <= ~stall;
                        state        <= WRITE;
                    end else if (ar_hs) begin
                        idx     <= bus.i_araddr[IDX_HI:IDX_LO];
                        cnt     <= bus.i_arlen;
                        last_rd <= 1'b1;
                        state   <= READ_FETCH;
                    end
                end
                WRITE: begin
                    bus.o_wready <= ~stall;
                    if (w_hs) begin
                        idx <= idx + MEM_AW'(1);
                        cnt <= cnt - 8'd1;
                        if (cnt == 8'd0) begin
                            bus.o_wready <= 1'b0;
                            bus.o_bvalid <= 1'b1;
                            state        <= WRESP;
                        end
                    end
                end
                WRESP: begin
                    if (bus.i_bready) begin
                        bus.o_bvalid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                READ_FETCH: begin
                    bus.o_rvalid <= 1'b1;
                    bus.o_rlast  <= (cnt == 8'd0);
                    state        <= READ;
                end
                READ: begin
                    if (r_hs) begin
                        if (cnt == 8'd0) begin
                            bus.o_rvalid <= 1'b0;
                            bus.o_rlast  <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            idx          <= idx + MEM_AW'(1);
                            cnt          <= cnt - 8'd1;
                            bus.o_rlast  <= (cnt == 8'd1);
                            bus.o_rvalid <= ~stall;
                        end
                    end else if (!bus.o_rvalid) begin
                        bus.o_rvalid <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: table of bursts plus hand-written
// arbitration, wlast-error and mid-burst reset sequences.
module tb_axi_sram_slave;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    axi_sram_slave_if #(.AW(25), .DW(16)) bus ();

    axi_sram_slave #(.AW(25), .DW(16), .D_LEVEL(1), .MEM_AW(10)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [24:0] addr;
        logic [7:0]  len;
        logic [15:0] d0;
        bit          tog;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write burst of beats d0+b; wlast also raised on beat bad_beat when >= 0.
    task automatic w_burst(input logic [24:0] addr, input logic [7:0] len,
                           input logic [15:0] d0, input int bad_beat, input bit hold_ar);
        @(negedge clk);
        bus.i_awvalid = 1'b1;
        bus.i_awaddr  = addr;
        bus.i_awlen   = len;
        if (hold_ar) bus.i_arvalid = 1'b1;
        #1;
        for (int i = 0; i < 16 && !bus.o_awready; i++) begin
            @(negedge clk); #1;
        end
        chk("aw_ready", 32'(bus.o_awready), 32'd1);
        chk("aw_excl_ar", 32'(bus.o_arready), 32'd0);
        for (int b = 0; b <= int'(len); b++) begin
            @(negedge clk);
            bus.i_awvalid = 1'b0;
            bus.i_wvalid  = 1'b1;
            bus.i_wdata   = d0 + 16'(b);
            bus.i_wlast   = (b == int'(len)) || (b == bad_beat);
            #1;
            for (int i = 0; i < 16 && !bus.o_wready; i++) begin
                @(negedge clk); #1;
            end
            chk("w_ready", 32'(bus.o_wready), 32'd1);
        end
        @(negedge clk);
        bus.i_wvalid = 1'b0;
        bus.i_wlast  = 1'b0;
        bus.i_bready = 1'b1;
        #1;
        chk("b_valid", 32'(bus.o_bvalid), 32'd1);
        chk("w_ready_off", 32'(bus.o_wready), 32'd0);
        @(negedge clk);
        bus.i_bready = 1'b0;
        #1;
        chk("b_valid_off", 32'(bus.o_bvalid), 32'd0);
    endtask

    // Read data phase, entered just before the posedge carrying the AR handshake.
    task automatic r_finish(input logic [7:0] len, input logic [15:0] d0, input bit tog);
        int beat;
        int k;
        beat = 0;
        k    = 0;
        @(negedge clk);
        bus.i_arvalid = 1'b0;
        #1;
        chk("r_fetch_novalid", 32'(bus.o_rvalid), 32'd0);
        while (beat <= int'(len) && k < 4 * int'(len) + 16) begin
            @(negedge clk);
            bus.i_rready = tog ? (k % 2 == 0) : 1'b1;
            #1;
            chk("r_valid", 32'(bus.o_rvalid), 32'd1);
            chk("r_data", 32'(bus.o_rdata), 32'(d0 + 16'(beat)));
            chk("r_last", 32'(bus.o_rlast), 32'(beat == int'(len)));
            if (bus.i_rready && bus.o_rvalid) beat++;
            k++;
        end
        chk("r_beats", 32'(beat), 32'(int'(len) + 1));
        @(negedge clk);
        bus.i_rready = 1'b0;
        #1;
        chk("r_valid_off", 32'(bus.o_rvalid), 32'd0);
    endtask

    task automatic r_burst(input logic [24:0] addr, input logic [7:0] len,
                           input logic [15:0] d0, input bit tog);
        @(negedge clk);
        bus.i_arvalid = 1'b1;
        bus.i_araddr  = addr;
        bus.i_arlen   = len;
        #1;
        for (int i = 0; i < 16 && !bus.o_arready; i++) begin
            @(negedge clk); #1;
        end
        chk("ar_ready", 32'(bus.o_arready), 32'd1);
        r_finish(len, d0, tog);
    endtask

    function automatic logic [31:0] all_out();
        return 32'({bus.o_awready, bus.o_wready, bus.o_bvalid, bus.o_arready,
                    bus.o_rvalid, bus.o_rlast, bus.o_err, bus.o_rdata});
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.i_awvalid = 1'b0; bus.i_awaddr = '0; bus.i_awlen = '0;
        bus.i_wvalid  = 1'b0; bus.i_wlast  = 1'b0; bus.i_wdata = '0;
        bus.i_bready  = 1'b0;
        bus.i_arvalid = 1'b0; bus.i_araddr = '0; bus.i_arlen = '0;
        bus.i_rready  = 1'b0;

        // Word index = addr >> 1, modulo 1024.
        tbl[0] = '{1'b1, 25'h000, 8'd7, 16'h1000, 1'b0};
        tbl[1] = '{1'b0, 25'h000, 8'd7, 16'h1000, 1'b0};
        tbl[2] = '{1'b1, 25'h7F8, 8'd7, 16'h2000, 1'b0};  // words 1020..1023, 0..3
        tbl[3] = '{1'b0, 25'h000, 8'd3, 16'h2004, 1'b0};
        tbl[4] = '{1'b0, 25'h7F8, 8'd3, 16'h2000, 1'b0};
        tbl[5] = '{1'b0, 25'h008, 8'd3, 16'h1004, 1'b0};
        tbl[6] = '{1'b1, 25'h100, 8'd0, 16'hBEEF, 1'b0};  // word 128
        tbl[7] = '{1'b0, 25'h900, 8'd0, 16'hBEEF, 1'b0};  // aliases word 128
        tbl[8] = '{1'b1, 25'h400, 8'd7, 16'h4000, 1'b0};
        tbl[9] = '{1'b0, 25'h400, 8'd7, 16'h4000, 1'b1};  // rready 1,0,1,0...

        @(negedge clk); #1;
        chk("reset_outputs", all_out(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 10; v++) begin
            if (tbl[v].wr) w_burst(tbl[v].addr, tbl[v].len, tbl[v].d0, -1, 1'b0);
            else           r_burst(tbl[v].addr, tbl[v].len, tbl[v].d0, tbl[v].tog);
        end
        chk("err_clean", 32'(bus.o_err), 32'd0);

        // Arbitration from reset: first conflict goes to write.
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        bus.i_awvalid = 1'b1; bus.i_arvalid = 1'b1;
        #1;
        chk("arb_reset_aw", 32'(bus.o_awready), 32'd1);
        chk("arb_reset_ar", 32'(bus.o_arready), 32'd0);
        #1;
        bus.i_awvalid = 1'b0; bus.i_arvalid = 1'b0;
        bus.i_araddr = 25'h040; bus.i_arlen = 8'd0;
        w_burst(25'h040, 8'd0, 16'h5A5A, -1, 1'b1);
        chk("arb_read_after_b", 32'(bus.o_arready), 32'd1);
        r_finish(8'd0, 16'h5A5A, 1'b0);
        @(negedge clk);
        bus.i_awvalid = 1'b1; bus.i_arvalid = 1'b1;
        #1;
        chk("arb_after_read_aw", 32'(bus.o_awready), 32'd1);
        chk("arb_after_read_ar", 32'(bus.o_arready), 32'd0);
        #1;
        bus.i_awvalid = 1'b0; bus.i_arvalid = 1'b0;
        w_burst(25'h040, 8'd0, 16'h6B6B, -1, 1'b0);
        @(negedge clk);
        bus.i_awvalid = 1'b1; bus.i_arvalid = 1'b1;
        #1;
        chk("arb_after_write_ar", 32'(bus.o_arready), 32'd1);
        chk("arb_after_write_aw", 32'(bus.o_awready), 32'd0);
        #1;
        bus.i_awvalid = 1'b0; bus.i_arvalid = 1'b0;

        // Early wlast: sticky error, burst still runs to awlen+1 beats.
        chk("err_before", 32'(bus.o_err), 32'd0);
        w_burst(25'h200, 8'd7, 16'h3000, 3, 1'b0);
        chk("err_set", 32'(bus.o_err), 32'd1);
        w_burst(25'h240, 8'd0, 16'h1111, -1, 1'b0);
        chk("err_sticky", 32'(bus.o_err), 32'd1);
        r_burst(25'h200, 8'd7, 16'h3000, 1'b0);

        // Reset while beat 3 of a read is on the bus.
        @(negedge clk);
        bus.i_arvalid = 1'b1; bus.i_araddr = 25'h200; bus.i_arlen = 8'd7;
        #1;
        chk("rst_ar_ready", 32'(bus.o_arready), 32'd1);
        @(negedge clk); bus.i_arvalid = 1'b0;
        @(negedge clk); bus.i_rready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); bus.i_rready = 1'b0;
        #1;
        chk("rst_beat3_data", 32'(bus.o_rdata), 32'h3003);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", all_out(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        r_burst(25'h200, 8'd7, 16'h3000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
